calendar_date_counter: RTL and testbench
========================================

Name: calendar_date_counter

Overview:
- Sequential day/month calendar stage that sits directly upstream of the 31-day month decoder.
- Holds the current date and advances it one day per `tick`.
- Drives the 4-bit month code that the decoder consumes: month[3]=A, month[2]=B, month[1]=C, month[0]=D (MSB first).
- Computes the month-length rule internally, so day rollover is self-contained, and also exports a registered day-of-year count.

Parameters:
- RESET_DAY, 1, day value loaded on reset; legal range 1..28.
- RESET_MONTH, 1, month value loaded on reset; legal range 1..12.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  advance date by one day; single-cycle strobe.
- load  input  1  synchronous date load strobe.
- load_day  input  5  day value for load (1..31).
- load_month  input  4  month value for load (1..12).
- leap  input  1  current year is a leap year; used only under LEAP_YEAR_EN.
- day  output  5  current day of month, 1..31.
- month  output  4  current month, 1..12, binary (1=Jan ... 12=Dec).
- day_of_year  output  9  current day of year, 1..366.
- month_31  output  1  combinational: month is one of 1,3,5,7,8,10,12.
- month_end  output  1  one-cycle pulse: the day just rolled over from the last day of the month.
- year_wrap  output  1  one-cycle pulse: Dec 31 rolled over to Jan 1.
- load_err  output  1  one-cycle pulse: a load was rejected.

Behaviour:
- Reset values:
  - day=RESET_DAY, month=RESET_MONTH.
  - day_of_year = cumulative non-leap offset of RESET_MONTH + RESET_DAY.
  - month_end, year_wrap and load_err are 0.
- Asserting rst_n low mid-operation forces the reset values immediately, independent of clk.
- last_day(m):
  - 31 if m is in {1,3,5,7,8,10,12}.
  - 30 if m is in {4,6,9,11}.
  - 28 if m=2 (29 under LEAP_YEAR_EN with leap=1).
- All state updates occur on the rising edge of clk. Priority order: reset > load > tick.
- tick=1, load=0:
  - If day < last_day(month): day+1, day_of_year+1.
  - If day == last_day(month): day=1 and month_end=1 on the following cycle.
    - If month < 12: month+1, day_of_year+1.
    - If month == 12: month=1, day_of_year=1, year_wrap=1 (asserted in the same cycle as month_end).
- load=1:
  - Accept when 1<=load_month<=12 and 1<=load_day<=last_day(load_month). On accept: day/month take the load values and day_of_year = cumulative offset of load_month + load_day.
  - Otherwise the state is unchanged and load_err=1 for one cycle.
  - A tick coincident with load is dropped. Neither month_end nor year_wrap fires.
- Pulse outputs are registered and high for exactly one cycle per event. Back-to-back ticks produce back-to-back correct updates; there is no tick-rate limit.
- month_31 is decoded combinationally from the registered month, with zero latency after a month change. It is 0 for codes 0 and 13..15, which are unreachable.
- Width rules:
  - day_of_year is unsigned 9-bit. Cumulative offsets come from a 12-entry constant table.
  - Under LEAP_YEAR_EN, offsets for months >=3 add 1 when leap=1.
- leap changing while month > 2 does not retroactively change day_of_year. The new value takes effect only on the next load or year_wrap.
- Illegal states are unreachable; no recovery logic is required.

Optional Feature:
- Macro: LEAP_YEAR_EN.
- Defined:
  - February last_day = 29 when leap=1, otherwise 28.
  - day_of_year reaches 366 on Dec 31 of a leap year.
  - A load of Feb 29 is accepted when leap=1 and rejected with load_err when leap=0.
- Undefined:
  - February is always 28 days and the leap input is ignored. The port stays present so the interface is unchanged.
  - A load of Feb 29 always raises load_err.
  - day_of_year maxes at 365.

Test Plan:
- Reset with rst_n=0 asynchronously mid-count (day=17, month=6) -> immediately day=1, month=1, day_of_year=1, all pulses 0; month_31=1.
- load day=30, month=4, then 1 tick -> day=1, month=5, day_of_year=121, month_end=1 for one cycle, month_31 changes 0->1.
- load day=31, month=12, then 1 tick -> day=1, month=1, day_of_year=1, month_end=1 and year_wrap=1 in the same cycle, for one cycle each.
- load day=28, month=2, leap=1, then 1 tick:
  - LEAP_YEAR_EN defined -> day=29, month=2.
  - LEAP_YEAR_EN undefined -> day=1, month=3.
  - Then load Feb 29 with leap=0 -> load_err pulse, state unchanged.
- Invalid loads: (day=31, month=4), (day=0, month=5), (day=5, month=13) -> load_err pulse each, state unchanged; load and tick in the same cycle with a valid load -> load value taken, tick ignored.
- Run 365 consecutive ticks from Jan 1 with leap=0 -> exactly 12 month_end pulses, 1 year_wrap, back at Jan 1. The month sequence 1..12 seen at the decoder yields month_31=1 exactly for months 1,3,5,7,8,10,12.

Source files
------------

// File: rtl/calendar_date_counter_if.sv
// Date-counter bus: the control strobes and load values going into the calendar stage,
// and the date/pulse outputs it drives towards the 31-day month decoder.
interface calendar_date_counter_if;
  logic       tick;
  logic       load;
  logic [4:0] load_day;
  logic [3:0] load_month;
  logic       leap;
  logic [4:0] day;
  logic [3:0] month;
  logic [8:0] day_of_year;
  logic       month_31;
  logic       month_end;
  logic       year_wrap;
  logic       load_err;

  modport master (
    output tick, load, load_day, load_month, leap,
    input  day, month, day_of_year, month_31, month_end, year_wrap, load_err
  );

  modport slave (
    input  tick, load, load_day, load_month, leap,
    output day, month, day_of_year, month_31, month_end, year_wrap, load_err
  );
endinterface

// File: rtl/calendar_date_counter.sv
// Day/month calendar stage with registered day-of-year and one-cycle event pulses.
// Optional feature macro: LEAP_YEAR_EN (29-day February when bus.leap=1).
module calendar_date_counter #(
  parameter int RESET_DAY   = 1,
  parameter int RESET_MONTH = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  calendar_date_counter_if.slave  bus
);

  // Days elapsed before the first of month m in a non-leap year.
  function automatic logic [8:0] month_offset(input logic [3:0] m);
    logic [8:0] off;
    off = 9'd0;
    case (m)
      4'd1:  off = 9'd0;
      4'd2:  off = 9'd31;
      4'd3:  off = 9'd59;
      4'd4:  off = 9'd90;
      4'd5:  off = 9'd120;
      4'd6:  off = 9'd151;
      4'd7:  off = 9'd181;
      4'd8:  off = 9'd212;
      4'd9:  off = 9'd243;
      4'd10: off = 9'd273;
      4'd11: off = 9'd304;
      4'd12: off = 9'd334;
      default: off = 9'd0;
    endcase
    return off;
  endfunction

  // Unreachable month codes return 0 so any load against them is rejected.
  function automatic logic [4:0] last_day(input logic [3:0] m, input logic lp);
    logic [4:0] ld;
    ld = 5'd0;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: ld = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                     ld = 5'd30;
      4'd2:                                        ld = lp ? 5'd29 : 5'd28;
      default:                                     ld = 5'd0;
    endcase
    return ld;
  endfunction

  localparam logic [4:0] RESET_DAY_V   = 5'(RESET_DAY);
  localparam logic [3:0] RESET_MONTH_V = 4'(RESET_MONTH);
  localparam logic [8:0] RESET_DOY     = month_offset(RESET_MONTH_V) + 9'(RESET_DAY_V);

  logic leap_eff;
`ifdef LEAP_YEAR_EN
  assign leap_eff = bus.leap;
`else
  logic leap_unused;
  assign leap_unused = bus.leap;
  assign leap_eff    = 1'b0;
`endif

  logic [4:0] day_q, day_d;
  logic [3:0] month_q, month_d;
  logic [8:0] doy_q, doy_d;
  logic       month_end_q, month_end_d;
  logic       year_wrap_q, year_wrap_d;
  logic       load_err_q, load_err_d;
  logic       load_ok;
  logic [8:0] load_doy;

  assign load_ok = (bus.load_month >= 4'd1) && (bus.load_month <= 4'd12) &&
                   (bus.load_day >= 5'd1) &&
                   (bus.load_day <= last_day(bus.load_month, leap_eff));

  // Leap correction only applies to months after February.
  assign load_doy = month_offset(bus.load_month) + 9'(bus.load_day) +
                    9'(leap_eff && (bus.load_month >= 4'd3));

  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    doy_d       = doy_q;
    month_end_d = 1'b0;
    year_wrap_d = 1'b0;
    load_err_d  = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        day_d   = bus.load_day;
        month_d = bus.load_month;
        doy_d   = load_doy;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.tick) begin
      if (day_q < last_day(month_q, leap_eff)) begin
        day_d = day_q + 5'd1;
        doy_d = doy_q + 9'd1;
      end else begin
        day_d       = 5'd1;
        month_end_d = 1'b1;
        if (month_q == 4'd12) begin
          month_d     = 4'd1;
          doy_d       = 9'd1;
          year_wrap_d = 1'b1;
        end else begin
          month_d = month_q + 4'd1;
          doy_d   = doy_q + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q       <= RESET_DAY_V;
      month_q     <= RESET_MONTH_V;
      doy_q       <= RESET_DOY;
      month_end_q <= 1'b0;
      year_wrap_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      day_q       <= day_d;
      month_q     <= month_d;
      doy_q       <= doy_d;
      month_end_q <= month_end_d;
      year_wrap_q <= year_wrap_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.day         = day_q;
  assign bus.month       = month_q;
  assign bus.day_of_year = doy_q;
  assign bus.month_end   = month_end_q;
  assign bus.year_wrap   = year_wrap_q;
  assign bus.load_err    = load_err_q;
  assign bus.month_31    = (month_q == 4'd1) || (month_q == 4'd3) || (month_q == 4'd5) ||
                           (month_q == 4'd7) || (month_q == 4'd8) || (month_q == 4'd10) ||
                           (month_q == 4'd12);

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed table-driven bench for calendar_date_counter, plus async-reset and full-year sequences.
module tb_calendar_date_counter;

  logic clk;
  logic rst_n;
  int   assertions;
  int   failures;

  calendar_date_counter_if bus();

  calendar_date_counter #(.RESET_DAY(1), .RESET_MONTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ld;
    logic       tk;
    logic [4:0] ldd;
    logic [3:0] ldm;
    logic       lp;
    logic [4:0] ed;
    logic [3:0] em;
    logic [8:0] edoy;
    logic       eme;
    logic       eyw;
    logic       eerr;
    logic       em31;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic ld, logic tk, int ldd, int ldm, logic lp,
                              int ed, int em, int edoy, logic eme, logic eyw, logic eerr,
                              logic em31);
    vec_t v;
    v.name = name; v.ld = ld; v.tk = tk; v.ldd = 5'(ldd); v.ldm = 4'(ldm); v.lp = lp;
    v.ed = 5'(ed); v.em = 4'(em); v.edoy = 9'(edoy);
    v.eme = eme; v.eyw = eyw; v.eerr = eerr; v.em31 = em31;
    return v;
  endfunction

  // Drives one cycle of strobes; returns just after the capturing edge with strobes dropped.
  task automatic applyStimulus(input logic ld, input logic tk, input logic [4:0] ldd,
                               input logic [3:0] ldm, input logic lp);
    @(negedge clk);
    bus.load       = ld;
    bus.tick       = tk;
    bus.load_day   = ldd;
    bus.load_month = ldm;
    bus.leap       = lp;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.tick = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] ed, input logic [3:0] em,
                             input logic [8:0] edoy, input logic eme, input logic eyw,
                             input logic eerr, input logic em31);
    assertions++;
    if (bus.day !== ed || bus.month !== em || bus.day_of_year !== edoy ||
        bus.month_end !== eme || bus.year_wrap !== eyw || bus.load_err !== eerr ||
        bus.month_31 !== em31) begin
      failures++;
      $display("[TB] FAIL %s: got d=%0d m=%0d doy=%0d me=%b yw=%b err=%b m31=%b, expected d=%0d m=%0d doy=%0d me=%b yw=%b err=%b m31=%b",
               name, bus.day, bus.month, bus.day_of_year, bus.month_end, bus.year_wrap,
               bus.load_err, bus.month_31, ed, em, edoy, eme, eyw, eerr, em31);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    assertions++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int mlen[12];
    int exp_d, exp_m, exp_doy;
    logic exp_me, exp_yw;
    int me_count, yw_count;

    mlen = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    assertions = 0;
    failures   = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.load = 1'b0;
    bus.load_day = 5'd0;
    bus.load_month = 4'd0;
    bus.leap = 1'b0;

    //           name            ld tk ldd ldm lp  d   m  doy  me yw err m31
    vecs.push_back(mk("ld_apr30",   1, 0, 30, 4,  0, 30, 4, 120, 0, 0, 0, 0));
    vecs.push_back(mk("tk_may1",    0, 1, 0,  0,  0, 1,  5, 121, 1, 0, 0, 1));
    vecs.push_back(mk("tk_may2",    0, 1, 0,  0,  0, 2,  5, 122, 0, 0, 0, 1));
    vecs.push_back(mk("ld_dec31",   1, 0, 31, 12, 0, 31, 12, 365, 0, 0, 0, 1));
    vecs.push_back(mk("tk_newyear", 0, 1, 0,  0,  0, 1,  1, 1,   1, 1, 0, 1));
    vecs.push_back(mk("ld_feb28",   1, 0, 28, 2,  1, 28, 2, 59,  0, 0, 0, 0));
`ifdef LEAP_YEAR_EN
    vecs.push_back(mk("tk_feb29",   0, 1, 0,  0,  1, 29, 2, 60,  0, 0, 0, 0));
    vecs.push_back(mk("ld29_nolp",  1, 0, 29, 2,  0, 29, 2, 60,  0, 0, 1, 0));
    vecs.push_back(mk("ld29_lp",    1, 0, 29, 2,  1, 29, 2, 60,  0, 0, 0, 0));
    vecs.push_back(mk("ld_mar1_lp", 1, 0, 1,  3,  1, 1,  3, 61,  0, 0, 0, 1));
    vecs.push_back(mk("ld_dec31lp", 1, 0, 31, 12, 1, 31, 12, 366, 0, 0, 0, 1));
`else
    vecs.push_back(mk("tk_mar1",    0, 1, 0,  0,  1, 1,  3, 60,  1, 0, 0, 1));
    vecs.push_back(mk("ld29_nolp",  1, 0, 29, 2,  0, 1,  3, 60,  0, 0, 1, 1));
    vecs.push_back(mk("ld29_lp",    1, 0, 29, 2,  1, 1,  3, 60,  0, 0, 1, 1));
    vecs.push_back(mk("ld_mar1_lp", 1, 0, 1,  3,  1, 1,  3, 60,  0, 0, 0, 1));
    vecs.push_back(mk("ld_dec31lp", 1, 0, 31, 12, 1, 31, 12, 365, 0, 0, 0, 1));
`endif
    vecs.push_back(mk("tk_wrap_lp", 0, 1, 0,  0,  1, 1,  1, 1,   1, 1, 0, 1));
    vecs.push_back(mk("bad_apr31",  1, 0, 31, 4,  0, 1,  1, 1,   0, 0, 1, 1));
    vecs.push_back(mk("bad_day0",   1, 0, 0,  5,  0, 1,  1, 1,   0, 0, 1, 1));
    vecs.push_back(mk("bad_mon13",  1, 0, 5,  13, 0, 1,  1, 1,   0, 0, 1, 1));
    vecs.push_back(mk("bad_mon0",   1, 1, 5,  0,  0, 1,  1, 1,   0, 0, 1, 1));
    vecs.push_back(mk("ld_tick",    1, 1, 15, 7,  0, 15, 7, 196, 0, 0, 0, 1));
    vecs.push_back(mk("ld_tk_eom",  1, 1, 30, 6,  0, 30, 6, 181, 0, 0, 0, 0));
    vecs.push_back(mk("tk_jul1",    0, 1, 0,  0,  0, 1,  7, 182, 1, 0, 0, 1));
    vecs.push_back(mk("tk_jul2",    0, 1, 0,  0,  0, 2,  7, 183, 0, 0, 0, 1));

    #12;
    checkOutput("reset_hold", 5'd1, 4'd1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].tk, vecs[i].ldd, vecs[i].ldm, vecs[i].lp);
      checkOutput(vecs[i].name, vecs[i].ed, vecs[i].em, vecs[i].edoy, vecs[i].eme,
                  vecs[i].eyw, vecs[i].eerr, vecs[i].em31);
    end

    // Async reset mid-count, between clock edges, right after a load_err pulse.
    applyStimulus(1'b1, 1'b0, 5'd17, 4'd6, 1'b0);
    checkOutput("ld_jun17", 5'd17, 4'd6, 9'd168, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd31, 4'd6, 1'b0);
    checkOutput("bad_jun31", 5'd17, 4'd6, 9'd168, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 5'd1, 4'd1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full non-leap year with tick held high every cycle.
    exp_d = 1; exp_m = 1; exp_doy = 1;
    me_count = 0; yw_count = 0;
    @(negedge clk);
    bus.leap = 1'b0;
    bus.tick = 1'b1;
    for (int i = 0; i < 365; i++) begin
      exp_me = 1'b0;
      exp_yw = 1'b0;
      if (exp_d < mlen[exp_m-1]) begin
        exp_d++;
        exp_doy++;
      end else begin
        exp_d  = 1;
        exp_me = 1'b1;
        if (exp_m == 12) begin
          exp_m  = 1;
          exp_doy = 1;
          exp_yw = 1'b1;
        end else begin
          exp_m++;
          exp_doy++;
        end
      end
      @(posedge clk);
      #1;
      if (i == 364) bus.tick = 1'b0;
      if (bus.month_end === 1'b1) me_count++;
      if (bus.year_wrap === 1'b1) yw_count++;
      checkOutput($sformatf("year_tick%0d", i + 1), 5'(exp_d), 4'(exp_m), 9'(exp_doy),
                  exp_me, exp_yw, 1'b0, (mlen[exp_m-1] == 31));
    end
    checkCount("month_end_count", me_count, 12);
    checkCount("year_wrap_count", yw_count, 1);
    @(posedge clk);
    #1;
    checkOutput("year_idle", 5'd1, 4'd1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
